// File: rtl/float_arith_unit.sv
// Single-cycle float unit: add, subtract, int-to-float and compare, registered outputs.
// Define FLOAT_ARITH_DEBUG_EN to register the internal observation word on debug.
module float_arith_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [1:0]  cmp,
  output logic        valid,
  output logic [31:0] debug
);

  localparam logic [1:0]  OP_CMP = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  // Denormals decode with a zero mantissa so they behave as zero everywhere.
  assign w_sa     = a[31];
  assign w_sb     = b[31] ^ op[0];
  assign w_ea     = a[30:23];
  assign w_eb     = b[30:23];
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_ma     = w_a_zero ? 24'h0 : {1'b1, a[22:0]};
  assign w_mb     = w_b_zero ? 24'h0 : {1'b1, b[22:0]};
  assign w_a_nan  = (w_ea == 8'hFF) && (a[22:0] != 23'h0);
  assign w_b_nan  = (w_eb == 8'hFF) && (b[22:0] != 23'h0);
  assign w_a_inf  = (w_ea == 8'hFF) && (a[22:0] == 23'h0);
  assign w_b_inf  = (w_eb == 8'hFF) && (b[22:0] == 23'h0);

  logic        w_a_big, w_sl, w_ss, w_eff_sub;
  logic [7:0]  w_el, w_es, w_exp_diff;
  logic [23:0] w_ml, w_ms, w_ms_al;
  logic [24:0] w_sum;
  logic [5:0]  w_lz_sub;
  logic [22:0] w_frac_sub;
  logic [8:0]  w_exp_carry;
  logic [31:0] w_addsub_res;

  always_comb begin
    w_a_big     = {w_ea, w_ma} >= {w_eb, w_mb};
    w_el        = w_a_big ? w_ea : w_eb;
    w_es        = w_a_big ? w_eb : w_ea;
    w_ml        = w_a_big ? w_ma : w_mb;
    w_ms        = w_a_big ? w_mb : w_ma;
    w_sl        = w_a_big ? w_sa : w_sb;
    w_ss        = w_a_big ? w_sb : w_sa;
    w_exp_diff  = w_el - w_es;
    w_ms_al     = (w_exp_diff >= 8'd25) ? 24'h0 : (w_ms >> w_exp_diff);
    w_eff_sub   = w_sl ^ w_ss;
    w_sum       = w_eff_sub ? ({1'b0, w_ml} - {1'b0, w_ms_al})
                            : ({1'b0, w_ml} + {1'b0, w_ms_al});
    w_lz_sub    = clz32({w_sum[23:0], 8'h00});
    w_frac_sub  = 23'(w_sum[23:0] << w_lz_sub);
    w_exp_carry = {1'b0, w_el} + 9'd1;

    w_addsub_res = 32'h0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      w_addsub_res = QNAN;
    end else if (w_a_inf) begin
      w_addsub_res = {w_sa, 8'hFF, 23'h0};
    end else if (w_b_inf) begin
      w_addsub_res = {w_sb, 8'hFF, 23'h0};
    end else if (w_sum == 25'h0) begin
      w_addsub_res = 32'h0;
    end else if (w_eff_sub) begin
      // Cancellation can push the exponent below the normal range: flush to signed zero.
      if (w_el <= {2'b00, w_lz_sub}) begin
        w_addsub_res = {w_sl, 31'h0};
      end else begin
        w_addsub_res = {w_sl, w_el - {2'b00, w_lz_sub}, w_frac_sub};
      end
    end else if (w_sum[24]) begin
      if (w_exp_carry >= 9'd255) begin
        w_addsub_res = {w_sl, 8'hFF, 23'h0};
      end else begin
        w_addsub_res = {w_sl, w_exp_carry[7:0], w_sum[23:1]};
      end
    end else begin
      w_addsub_res = {w_sl, w_el, w_sum[22:0]};
    end
  end

  logic [31:0] w_i_mag;
  logic [5:0]  w_lz_i;
  logic [22:0] w_i_frac;
  logic [7:0]  w_i_exp;
  logic [31:0] w_i2f_res;

  // Negating 0x80000000 wraps to itself, which is exactly the magnitude 2^31.
  assign w_i_mag   = a[31] ? (~a + 32'd1) : a;
  assign w_lz_i    = clz32(w_i_mag);
  assign w_i_frac  = 23'((w_i_mag << w_lz_i) >> 8);
  assign w_i_exp   = 8'd158 - {2'b00, w_lz_i};
  assign w_i2f_res = (a == 32'h0) ? 32'h0 : {a[31], w_i_exp, w_i_frac};

  logic        w_ca_s, w_cb_s;
  logic [30:0] w_ca_mag, w_cb_mag;
  logic [1:0]  w_cmp_code;

  always_comb begin
    w_ca_s     = a[31] & ~w_a_zero;
    w_cb_s     = b[31] & ~w_b_zero;
    w_ca_mag   = w_a_zero ? 31'h0 : a[30:0];
    w_cb_mag   = w_b_zero ? 31'h0 : b[30:0];
    w_cmp_code = 2'b00;
    if (w_a_nan || w_b_nan) begin
      w_cmp_code = 2'b10;
    end else if (w_ca_s != w_cb_s) begin
      w_cmp_code = w_cb_s ? 2'b01 : 2'b11;
    end else if (w_ca_mag != w_cb_mag) begin
      w_cmp_code = ((w_ca_mag > w_cb_mag) ^ w_ca_s) ? 2'b01 : 2'b11;
    end
  end

  logic [31:0] r_result;
  logic [1:0]  r_cmp;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 32'h0;
      r_cmp    <= 2'b00;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= enable;
      if (enable) begin
        if (op == OP_CMP) begin
          r_cmp <= w_cmp_code;
        end else begin
          r_result <= op[1] ? w_i2f_res : w_addsub_res;
        end
      end
    end
  end

  assign result = r_result;
  assign cmp    = r_cmp;
  assign valid  = r_valid;

`ifdef FLOAT_ARITH_DEBUG_EN
  logic [31:0] r_debug;
  logic [7:0]  w_dbg_exp, w_dbg_diff, w_dbg_shift;

  always_comb begin
    w_dbg_exp   = w_el;
    w_dbg_diff  = w_exp_diff;
    w_dbg_shift = w_eff_sub ? {2'b00, w_lz_sub} : 8'h00;
    if (op == 2'b10) begin
      w_dbg_exp   = w_i_exp;
      w_dbg_diff  = 8'h00;
      w_dbg_shift = {2'b00, w_lz_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_debug <= 32'h0;
    end else if (enable) begin
      r_debug <= {op, 6'b000000, w_dbg_exp, w_dbg_diff, w_dbg_shift};
    end
  end

  assign debug = r_debug;
`else
  assign debug = 32'h0;
`endif

endmodule

// File: tb/tb_float_arith_unit.sv
// Bench for float_arith_unit: directed vector table, reset/hold sequences, and
// random operations checked against a value-level float model.
module tb_float_arith_unit;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [1:0]  op;
  logic [31:0] a, b, result, debug;
  logic [1:0]  cmp;
  logic        valid;

  int total = 0;
  int bad = 0;
  logic [31:0] e_result;
  logic [1:0]  e_cmp;

  float_arith_unit dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .a(a), .b(b),
    .result(result), .cmp(cmp), .valid(valid), .debug(debug)
  );

  always #5 clk = ~clk;

  // Pack sign * mag * 2^exp2 into single precision, truncating toward zero.
  function automatic logic [31:0] pack(input bit s, input longint unsigned mag, input int exp2);
    int p, e;
    longint unsigned m;
    logic [31:0] r;
    if (mag == 0) return 32'h0;
    p = 63;
    while (mag[p] == 1'b0) p--;
    e = p + exp2 + 127;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    m = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
    r = {s, e[7:0], m[22:0]};
    return r;
  endfunction

  function automatic logic [31:0] m_addsub(input logic [31:0] x, input logic [31:0] y, input bit sub);
    bit sx, sy, xnan, ynan, xinf, yinf, sl, ss;
    int ex, ey, el, es, sh;
    longint unsigned mx, my, ml, ms, al, raw;
    sx = x[31];
    sy = y[31] ^ sub;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xnan = (ex == 255) && (x[22:0] != 0);
    ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0);
    yinf = (ey == 255) && (y[22:0] == 0);
    if (xnan || ynan) return 32'h7FC00000;
    if (xinf && yinf) return (sx == sy) ? {sx, 8'hFF, 23'h0} : 32'h7FC00000;
    if (xinf) return {sx, 8'hFF, 23'h0};
    if (yinf) return {sy, 8'hFF, 23'h0};
    mx = (ex == 0) ? 0 : (64'h800000 | 64'(x[22:0]));
    my = (ey == 0) ? 0 : (64'h800000 | 64'(y[22:0]));
    if (ex > ey || (ex == ey && mx >= my)) begin
      el = ex; es = ey; ml = mx; ms = my; sl = sx; ss = sy;
    end else begin
      el = ey; es = ex; ml = my; ms = mx; sl = sy; ss = sx;
    end
    sh = el - es;
    al = (sh >= 25) ? 0 : (ms >> sh);
    raw = (sl == ss) ? (ml + al) : (ml - al);
    return pack(sl, raw, el - 150);
  endfunction

  function automatic logic [31:0] m_i2f(input logic [31:0] x);
    longint v;
    bit s;
    longint unsigned mag;
    v = longint'($signed(x));
    s = (v < 0);
    mag = s ? longint'(-v) : longint'(v);
    return pack(s, mag, 0);
  endfunction

  function automatic longint fkey(input logic [31:0] x);
    longint mag;
    if (x[30:23] == 8'h00) return 0;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [1:0] m_cmp(input logic [31:0] x, input logic [31:0] y);
    longint kx, ky;
    if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0)) return 2'b10;
    kx = fkey(x);
    ky = fkey(y);
    if (kx == ky) return 2'b00;
    return (kx > ky) ? 2'b01 : 2'b11;
  endfunction

  function automatic logic [31:0] m_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == 2'b10) return m_i2f(x);
    return m_addsub(x, y, o[0]);
  endfunction

  function automatic logic [31:0] rnd_float(input logic [31:0] r);
    int k, e;
    logic [31:0] f;
    k = int'($urandom_range(0, 19));
    f = $urandom;
    case (k)
      0: f = {f[31], 31'h0};
      1: f = {f[31], 8'h00, f[22:0]};
      2: f = {f[31], 8'hFF, 23'h0};
      3: f = {f[31], 8'hFF, f[22:1], 1'b1};
      4: f = {f[31], r[30:0]};
      5, 6, 7, 8, 9: begin
        e = int'(r[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        f[30:23] = 8'(e);
      end
      10, 11: f[30:23] = 8'(250 + $urandom_range(0, 4));
      default: f[30:23] = 8'($urandom_range(1, 254));
    endcase
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  task automatic step(input logic exp_valid, input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, exp_valid});
    chk({tag, ".result"}, result, e_result);
    chk({tag, ".cmp"}, {30'b0, cmp}, {30'b0, e_cmp});
`ifndef FLOAT_ARITH_DEBUG_EN
    chk({tag, ".debug"}, debug, 32'h0);
`endif
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    op = o; a = x; b = y; enable = 1'b1;
    if (o == 2'b11) e_cmp = m_cmp(x, y);
    else e_result = m_calc(o, x, y);
    step(1'b1, tag);
    enable = 1'b0;
    $display("%s op=%0d a=%08h b=%08h result=%08h cmp=%0d", tag, o, x, y, result, cmp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expv;
  } vec_t;

  vec_t vecs[23];

  initial begin
    vecs[0]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[1]  = '{2'b01, 32'h40400000, 32'h40400000, 32'h00000000};
    vecs[2]  = '{2'b10, 32'h00000005, 32'h12345678, 32'h40A00000};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'h0,        32'hBF800000};
    vecs[4]  = '{2'b10, 32'h80000000, 32'h0,        32'hCF000000};
    vecs[5]  = '{2'b10, 32'h00000000, 32'h0,        32'h00000000};
    vecs[6]  = '{2'b10, 32'h7FFFFFFF, 32'h0,        32'h4EFFFFFF};
    vecs[7]  = '{2'b11, 32'h3F800000, 32'h40000000, 32'h00000003};
    vecs[8]  = '{2'b11, 32'h40000000, 32'h3F800000, 32'h00000001};
    vecs[9]  = '{2'b11, 32'h00000000, 32'h80000000, 32'h00000000};
    vecs[10] = '{2'b11, 32'h7FC00000, 32'h3F800000, 32'h00000002};
    vecs[11] = '{2'b11, 32'hBF800000, 32'hC0000000, 32'h00000001};
    vecs[12] = '{2'b11, 32'h7F800000, 32'h7F7FFFFF, 32'h00000001};
    vecs[13] = '{2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    vecs[14] = '{2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000};
    vecs[15] = '{2'b00, 32'h3F800000, 32'h30800000, 32'h3F800000};
    vecs[16] = '{2'b01, 32'h40000000, 32'h3F800000, 32'h3F800000};
    vecs[17] = '{2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000};
    vecs[18] = '{2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000};
    vecs[19] = '{2'b00, 32'h00000001, 32'h00000001, 32'h00000000};
    vecs[20] = '{2'b01, 32'h80800001, 32'h80800000, 32'h80000000};
    vecs[21] = '{2'b00, 32'hBF800000, 32'h3F800000, 32'h00000000};
    vecs[22] = '{2'b00, 32'h7FC00000, 32'h3F800000, 32'h7FC00000};

    reset = 1'b1; enable = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
    e_result = 32'h0; e_cmp = 2'b00;
    step(1'b0, "reset0");
    step(1'b0, "reset1");
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; enable = 1'b1;
      if (vecs[i].op == 2'b11) e_cmp = vecs[i].expv[1:0];
      else e_result = vecs[i].expv;
      step(1'b1, $sformatf("vec%0d", i));
      enable = 1'b0;
      $display("vec%0d op=%0d a=%08h b=%08h result=%08h cmp=%0d", i, vecs[i].op, vecs[i].a, vecs[i].b, result, cmp);
    end

    // Reset coinciding with an enable discards the operation.
    run_op(2'b11, 32'h3F800000, 32'h40000000, "pre_rst_cmp");
    run_op(2'b00, 32'h3F800000, 32'h40000000, "pre_rst_add");
    reset = 1'b1; enable = 1'b1; op = 2'b00; a = 32'h40000000; b = 32'h40000000;
    e_result = 32'h0; e_cmp = 2'b00;
    step(1'b0, "rst_en");
    reset = 1'b0; enable = 1'b0;
    step(1'b0, "rst_after");
    $display("reset-with-enable result=%08h cmp=%0d valid=%0d", result, cmp, valid);

    // Hold for five idle cycles while the inputs wander.
    run_op(2'b00, 32'h3F800000, 32'h40000000, "pre_hold");
    for (int i = 0; i < 5; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom; enable = 1'b0;
      step(1'b0, $sformatf("hold%0d", i));
    end
    $display("hold result=%08h", result);

    // Back-to-back enables, mixing result and compare paths.
    run_op(2'b10, 32'h00000005, 32'h0, "b2b0");
    run_op(2'b11, 32'h40000000, 32'h3F800000, "b2b1");
    run_op(2'b01, 32'h40400000, 32'h3F800000, "b2b2");

    for (int i = 0; i < 400; i++) begin
      logic [1:0]  o;
      logic [31:0] x, y;
      int r;
      r = int'($urandom_range(0, 49));
      o = 2'($urandom_range(0, 3));
      x = rnd_float($urandom);
      y = rnd_float(x);
      if (o == 2'b10 && $urandom_range(0, 3) == 0) x = 32'($signed(int'($urandom_range(0, 255)) - 128));
      if (r == 0) begin
        reset = 1'b1; enable = 1'($urandom_range(0, 1)); op = o; a = x; b = y;
        e_result = 32'h0; e_cmp = 2'b00;
        step(1'b0, $sformatf("rnd%0d_rst", i));
        reset = 1'b0; enable = 1'b0;
        $display("rnd%0d reset", i);
      end else if (r < 12) begin
        op = o; a = x; b = y; enable = 1'b0;
        step(1'b0, $sformatf("rnd%0d_idle", i));
      end else begin
        run_op(o, x, y, $sformatf("rnd%0d", i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_arith_unit.md
FLOAT_ARITH_UNIT -- requirements
Module: float_arith_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  in  1  reset, synchronous to clk, active-high.
REQ-003 SHALL have ports: enable  in  1  start operation, sampled on the clk edge.
REQ-004 SHALL have ports: op  in  2  operation select; 00 add, 01 subtract, 10 int-to-float, 11 compare.
REQ-005 SHALL have ports: a  in  32  operand A; IEEE-754 single for add, subtract and compare; signed two's-complement integer for int-to-float.
REQ-006 SHALL have ports: b  in  32  operand B, IEEE-754 single; ignored by int-to-float.
REQ-007 SHALL have ports: result  out  32  registered float result of add, subtract or int-to-float.
REQ-008 SHALL have ports: cmp  out  2  registered compare code.
REQ-009 SHALL have ports: valid  out  1  one-cycle pulse marking new result or cmp.
REQ-010 SHALL have ports: debug  out  32  internal observation word (see Configuration).

Function
REQ-011 SHALL sample a, b and op on a clk edge with enable=1 and reset=0, and present the outputs after that same edge (latency 1 cycle), with valid=1 for exactly that one cycle.
REQ-012 SHALL hold result and cmp unchanged while enable=0; back-to-back enables SHALL each produce a result on consecutive cycles.
REQ-013 Add SHALL compute a+b; subtract SHALL compute a-b by inverting b's sign.
REQ-014 Add and subtract SHALL align the smaller-exponent mantissa (hidden bit included) by right shift, with shifts of 25 or more giving zero, then add or subtract magnitudes, then normalise.
REQ-015 Add and subtract SHALL round toward zero, discarding shifted-out bits.
REQ-016 An exact-zero difference SHALL return +0 (0x00000000).
REQ-017 Denormal inputs SHALL be treated as zero; results below the normal range SHALL flush to signed zero.
REQ-018 Exponent overflow SHALL return signed infinity (0x7F800000 or 0xFF800000).
REQ-019 A NaN operand, or inf-inf of opposite effective signs, SHALL return 0x7FC00000.
REQ-020 A single infinite operand SHALL return that infinity, sign-adjusted for subtract.
REQ-021 Int-to-float SHALL convert signed 32-bit a, rounding toward zero.
REQ-022 Int-to-float of 0 SHALL give 0x00000000.
REQ-023 Int-to-float of 0x80000000 SHALL give 0xCF000000.
REQ-024 Compare SHALL set cmp=00 if a==b, 01 if a>b, 11 if a<b, and 10 if either operand is NaN.
REQ-025 Compare SHALL treat +0 and -0 as equal.
REQ-026 Compare SHALL leave result unchanged; add, subtract and int-to-float SHALL leave cmp unchanged.

Reset
REQ-027 When reset=1 at a clk edge: result=0x00000000, cmp=00, valid=0 and debug=0, regardless of enable.
REQ-028 Reset asserted on an enable edge SHALL discard that operation, and no valid pulse SHALL follow.

Configuration
REQ-029 Macro FLOAT_ARITH_DEBUG_EN, when defined: debug SHALL register on each accepted operation as {op[1:0], 6'b0, aligned exponent[7:0], exponent difference[7:0], normalise shift count[7:0]}.
REQ-030 Without FLOAT_ARITH_DEBUG_EN, debug SHALL be constant 0x00000000 and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Add and subtract: op=00, a=0x3F800000, b=0x40000000 -> result=0x40400000 with valid one cycle later; op=01, a=b=0x40400000 -> result=0x00000000.
REQ-032 Int-to-float: op=10, a=5 -> 0x40A00000; a=0xFFFFFFFF -> 0xBF800000; a=0x80000000 -> 0xCF000000.
REQ-033 Compare ordering: op=11 with (1.0, 2.0) -> cmp=11; (2.0, 1.0) -> cmp=01.
REQ-034 Compare special cases: (0x00000000, 0x80000000) -> cmp=00; (0x7FC00000, 1.0) -> cmp=10.
REQ-035 Special values: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; inf - inf -> 0x7FC00000.
REQ-036 Reset and hold: reset asserted together with enable -> valid stays 0 and outputs are 0; enable=0 for 5 cycles -> result stable.
